// File: rtl/pet_stat_bank_pkg.sv
// Shared types and default constants for the pet-stat bank.
package pet_stat_pkg;

    typedef enum logic {
        ST_DECAY  = 1'b0,
        ST_REFILL = 1'b1
    } stat_state_t;

    localparam int unsigned STAT_HUNGER = 0;
    localparam int unsigned STAT_SLEEP  = 1;

    localparam int unsigned DEF_MAX_LEVEL  = 100;
    localparam int unsigned DEF_LOW_THRESH = 20;

endpackage

// File: rtl/pet_stat_bank_channel.sv
// One stat channel: DECAY/REFILL FSM, saturating level register and status flags.
module stat_channel
    import pet_stat_pkg::*;
#(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int unsigned DECAY_STEP  = 1,
    parameter int unsigned REFILL_STEP = 5,
    parameter int unsigned LOW_THRESH  = DEF_LOW_THRESH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] level_o,
    output logic             refilling_o,
    output logic             done_o,
    output logic             low_o,
    output logic             empty_o
);

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0] LOW_L = WIDTH'(LOW_THRESH);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_LEVEL);
    localparam logic [WIDTH:0]   DEC_W = (WIDTH+1)'(DECAY_STEP);
    localparam logic [WIDTH:0]   INC_W = (WIDTH+1)'(REFILL_STEP);

    stat_state_t      state_q, state_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   dec_raw, inc_raw;
    logic [WIDTH-1:0] dec_sat, inc_sat;

    // One extra bit so an underflow shows up as the top bit rather than a wrap.
    always_comb begin
        dec_raw = {1'b0, level_q} - DEC_W;
        inc_raw = {1'b0, level_q} + INC_W;
        dec_sat = dec_raw[WIDTH] ? '0 : dec_raw[WIDTH-1:0];
        inc_sat = (inc_raw >= MAX_W) ? MAX_L : inc_raw[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;

        if (tick_i) begin
            level_d = (state_q == ST_REFILL) ? inc_sat : dec_sat;
        end

        unique case (state_q)
            ST_DECAY: begin
                if (start_i && !abort_i) begin
                    if (level_q == MAX_L) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (abort_i) begin
                    state_d = ST_DECAY;
                end else if (tick_i && (inc_sat == MAX_L)) begin
                    state_d = ST_DECAY;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_DECAY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_DECAY;
            level_q <= MAX_L;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    assign level_o     = level_q;
    assign refilling_o = (state_q == ST_REFILL);
    assign done_o      = done_q;
    assign low_o       = (level_q <= LOW_L);
    assign empty_o     = (level_q == '0);

endmodule

// File: rtl/pet_stat_bank.sv
// Multi-channel pet-stat engine: shared tick source plus NUM_STATS stat_channel instances.
// Optional PET_STAT_EXT_TICK_EN replaces the internal divider with an external tick_in.
module pet_stat_bank
    import pet_stat_pkg::*;
#(
    parameter int unsigned NUM_STATS   = 2,
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int unsigned DECAY_STEP  = 1,
    parameter int unsigned REFILL_STEP = 5,
    parameter int unsigned LOW_THRESH  = DEF_LOW_THRESH,
    parameter int unsigned TICK_DIV    = 50000000
) (
    input  logic                       clk,
    input  logic                       resetn,
`ifdef PET_STAT_EXT_TICK_EN
    input  logic                       tick_in,
`endif
    input  logic [NUM_STATS-1:0]       start,
    input  logic [NUM_STATS-1:0]       abort,
    output logic [NUM_STATS*WIDTH-1:0] level,
    output logic [NUM_STATS-1:0]       refilling,
    output logic [NUM_STATS-1:0]       done,
    output logic [NUM_STATS-1:0]       low,
    output logic [NUM_STATS-1:0]       empty,
    output logic                       tick
);

    logic tick_q, tick_d;
    logic chan_tick;

`ifdef PET_STAT_EXT_TICK_EN
    assign tick_d    = tick_in;
    assign chan_tick = tick_in;
`else
    localparam int unsigned       CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Channels act on the registered pulse so the tick output and level updates stay aligned.
    assign chan_tick = tick_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_chan
        stat_channel #(
            .WIDTH       (WIDTH),
            .MAX_LEVEL   (MAX_LEVEL),
            .DECAY_STEP  (DECAY_STEP),
            .REFILL_STEP (REFILL_STEP),
            .LOW_THRESH  (LOW_THRESH)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (resetn),
            .tick_i      (chan_tick),
            .start_i     (start[g]),
            .abort_i     (abort[g]),
            .level_o     (level[g*WIDTH +: WIDTH]),
            .refilling_o (refilling[g]),
            .done_o      (done[g]),
            .low_o       (low[g]),
            .empty_o     (empty[g])
        );
    end

endmodule

// File: tb/tb_pet_stat_bank.sv
// Table-driven scoreboard bench for pet_stat_bank (works with or without PET_STAT_EXT_TICK_EN).
module tb_pet_stat_bank;
    import pet_stat_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned W  = 7;

    logic          clk = 1'b0;
    logic          resetn;
`ifdef PET_STAT_EXT_TICK_EN
    logic          tick_in;
`endif
    logic [NS-1:0]   start, abort;
    logic [NS*W-1:0] level;
    logic [NS-1:0]   refilling, done, low, empty;
    logic            tick;

    always #5 clk = ~clk;

    pet_stat_bank #(
        .NUM_STATS   (NS),
        .WIDTH       (W),
        .MAX_LEVEL   (10),
        .DECAY_STEP  (1),
        .REFILL_STEP (3),
        .LOW_THRESH  (2),
        .TICK_DIV    (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
`ifdef PET_STAT_EXT_TICK_EN
        .tick_in   (tick_in),
`endif
        .start     (start),
        .abort     (abort),
        .level     (level),
        .refilling (refilling),
        .done      (done),
        .low       (low),
        .empty     (empty),
        .tick      (tick)
    );

    typedef enum int {OP_CYC, OP_TICK} op_t;

    typedef struct {
        string      name;
        op_t        op;
        logic [1:0] st;
        logic [1:0] ab;
        int         l0;
        int         l1;
        logic [1:0] r;
        logic [1:0] d;
        logic [1:0] lo;
        logic [1:0] e;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input op_t op, input logic [1:0] st, input logic [1:0] ab,
                       input int l0, input int l1, input logic [1:0] r, input logic [1:0] d,
                       input logic [1:0] lo, input logic [1:0] e);
        vec_t v;
        v.name = nm; v.op = op; v.st = st; v.ab = ab;
        v.l0 = l0; v.l1 = l1; v.r = r; v.d = d; v.lo = lo; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic step_cyc(input logic [1:0] st, input logic [1:0] ab);
        start = st;
        abort = ab;
        @(negedge clk);
        start = '0;
        abort = '0;
    endtask

    task automatic step_tick(input logic [1:0] st, input logic [1:0] ab);
`ifdef PET_STAT_EXT_TICK_EN
        tick_in = 1'b1;
        start   = st;
        abort   = ab;
        @(negedge clk);
        tick_in = 1'b0;
        start   = '0;
        abort   = '0;
`else
        int n = 0;
        while (tick !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_wait actual=%0d expected=1", tick);
        end
        step_cyc(st, ab);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t e;
        int   n;
        resetn = 1'b0;
        start  = '0;
        abort  = '0;
`ifdef PET_STAT_EXT_TICK_EN
        tick_in = 1'b0;
`endif

        for (int i = 1; i <= 9; i++) begin
            add($sformatf("decay%0d", i), OP_TICK, 2'b00, 2'b00, 10 - i, 10 - i, 2'b00, 2'b00,
                (10 - i <= 2) ? 2'b11 : 2'b00, 2'b00);
        end
        add("b1_start0",      OP_CYC,  2'b01, 2'b00,  1, 1, 2'b01, 2'b00, 2'b11, 2'b00);
        add("b2_refill4",     OP_TICK, 2'b00, 2'b00,  4, 0, 2'b01, 2'b00, 2'b10, 2'b10);
        add("b3_start_ign",   OP_CYC,  2'b01, 2'b00,  4, 0, 2'b01, 2'b00, 2'b10, 2'b10);
        add("b4_refill7",     OP_TICK, 2'b00, 2'b00,  7, 0, 2'b01, 2'b00, 2'b10, 2'b10);
        add("b5_full_done",   OP_TICK, 2'b00, 2'b00, 10, 0, 2'b00, 2'b01, 2'b10, 2'b10);
        add("b6_done_clr",    OP_CYC,  2'b00, 2'b00, 10, 0, 2'b00, 2'b00, 2'b10, 2'b10);
        add("d1_start_full",  OP_CYC,  2'b11, 2'b10, 10, 0, 2'b00, 2'b01, 2'b10, 2'b10);
        add("d2_done_clr",    OP_CYC,  2'b00, 2'b00, 10, 0, 2'b00, 2'b00, 2'b10, 2'b10);
        add("c1_tick_start1", OP_TICK, 2'b10, 2'b00,  9, 0, 2'b10, 2'b00, 2'b10, 2'b10);
        add("c2_refill3",     OP_TICK, 2'b00, 2'b00,  8, 3, 2'b10, 2'b00, 2'b00, 2'b00);
        add("c3_abort1",      OP_CYC,  2'b00, 2'b10,  8, 3, 2'b00, 2'b00, 2'b00, 2'b00);
        add("c4_decay",       OP_TICK, 2'b00, 2'b00,  7, 2, 2'b00, 2'b00, 2'b10, 2'b00);
        add("c5_decay",       OP_TICK, 2'b00, 2'b00,  6, 1, 2'b00, 2'b00, 2'b10, 2'b00);
        add("c6_tick_start0", OP_TICK, 2'b01, 2'b00,  5, 0, 2'b01, 2'b00, 2'b10, 2'b10);
        add("c7_refill8",     OP_TICK, 2'b00, 2'b00,  8, 0, 2'b01, 2'b00, 2'b10, 2'b10);
        add("c8_clamp_done",  OP_TICK, 2'b00, 2'b00, 10, 0, 2'b00, 2'b01, 2'b10, 2'b10);
        add("c9_abort_decay", OP_TICK, 2'b00, 2'b10,  9, 0, 2'b00, 2'b00, 2'b10, 2'b10);
        add("c10_start0",     OP_CYC,  2'b01, 2'b00,  9, 0, 2'b01, 2'b00, 2'b10, 2'b10);

        repeat (3) @(negedge clk);
        chk("rst_lvl0", level[STAT_HUNGER*W +: W], 10);
        chk("rst_lvl1", level[STAT_SLEEP*W +: W], 10);
        chk("rst_refilling", refilling, 0);
        chk("rst_done", done, 0);
        chk("rst_low", low, 0);
        chk("rst_empty", empty, 0);
        chk("rst_tick", tick, 0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i]);
            if (vecs[i].op == OP_TICK) step_tick(vecs[i].st, vecs[i].ab);
            else                       step_cyc(vecs[i].st, vecs[i].ab);
            e = exp_q.pop_front();
            chk({e.name, "_lvl0"}, level[STAT_HUNGER*W +: W], e.l0);
            chk({e.name, "_lvl1"}, level[STAT_SLEEP*W +: W], e.l1);
            chk({e.name, "_refilling"}, refilling, e.r);
            chk({e.name, "_done"}, done, e.d);
            chk({e.name, "_low"}, low, e.lo);
            chk({e.name, "_empty"}, empty, e.e);
        end

        // Channel 0 is mid-refill here; reset is dropped between clock edges.
        #3 resetn = 1'b0;
        #1;
        chk("async_lvl0", level[STAT_HUNGER*W +: W], 10);
        chk("async_lvl1", level[STAT_SLEEP*W +: W], 10);
        chk("async_refilling", refilling, 0);
        chk("async_done", done, 0);
        chk("async_low", low, 0);
        chk("async_tick", tick, 0);
        @(negedge clk);
        resetn = 1'b1;
        step_cyc(2'b00, 2'b00);
        chk("post_rst_refilling", refilling, 0);
        chk("post_rst_lvl0", level[STAT_HUNGER*W +: W], 10);

`ifdef PET_STAT_EXT_TICK_EN
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        chk("ext_tick_mirror", tick, 1);
        chk("ext_tick_lvl0", level[STAT_HUNGER*W +: W], 9);
        @(negedge clk);
        chk("ext_tick_width", tick, 0);
        repeat (3) @(negedge clk);
        chk("ext_no_tick_lvl1", level[STAT_SLEEP*W +: W], 9);
`else
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("tick_seen", tick, 1);
        @(negedge clk);
        chk("tick_width", tick, 0);
        n = 1;
        while (tick !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("tick_period", n, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pet_stat_bank.md
Name: pet_stat_bank

Overview:
Parametrised multi-channel pet-stat engine; successor to the fixed hunger and sleep counters.
- Holds NUM_STATS saturating level counters, e.g. ch0 hunger, ch1 sleep, ch2+ future stats such as play or hygiene.
- One shared internal tick divider drives all channels.
- Each channel decays on every tick while idle, and refills on every tick after a start request until full, then pulses done.
- Sits between the navigation FSM (source of start/abort) and the VGA/HEX stat display (consumer of levels and flags).

Parameters:
NUM_STATS, 2, number of independent stat channels (1..8)
WIDTH, 7, bits per level
MAX_LEVEL, 100, full level; must be < 2**WIDTH
DECAY_STEP, 1, amount subtracted per tick while decaying
REFILL_STEP, 5, amount added per tick while refilling
LOW_THRESH, 20, low flag asserted when level <= LOW_THRESH
TICK_DIV, 50000000, clk cycles per tick (>= 2)

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
start  in  NUM_STATS  per-channel refill request, one-cycle pulse (eat/sleep begins)
abort  in  NUM_STATS  per-channel cancel of an active refill
level  out  NUM_STATS*WIDTH  packed levels; channel i at bits [i*WIDTH +: WIDTH]
refilling  out  NUM_STATS  channel i is in REFILL
done  out  NUM_STATS  one-cycle pulse when a refill completes
low  out  NUM_STATS  level <= LOW_THRESH (combinational from the level register)
empty  out  NUM_STATS  level == 0
tick  out  1  one-cycle pulse on each divider wrap (display/debug)

Behaviour:
- Reset (asynchronous, resetn low):
  - every level = MAX_LEVEL; all channels in DECAY
  - done = 0, tick = 0, divider = 0
  - refilling = 0, low = 0, empty = 0
- Divider:
  - counts 0..TICK_DIV-1 and wraps to 0
  - tick is registered and is high for exactly the one cycle after the count equals TICK_DIV-1
  - period is exactly TICK_DIV cycles
- Per-channel FSM with states DECAY and REFILL:
  - DECAY, start=1, level<MAX_LEVEL: go to REFILL next cycle; refilling=1.
  - DECAY, start=1, level==MAX_LEVEL: stay in DECAY; done pulses on the next cycle.
  - DECAY, tick: level = max(level-DECAY_STEP, 0). Saturates at 0 and never wraps.
  - REFILL, tick: level = min(level+REFILL_STEP, MAX_LEVEL). When the result equals MAX_LEVEL, go to DECAY in the same update and pulse done for 1 cycle on the following cycle.
  - REFILL, abort=1: go to DECAY next cycle; level kept; no done pulse.
  - REFILL, start=1: ignored (no restart, no extra done).
- Simultaneous events:
  - start and abort in the same cycle: abort wins; the channel stays in or returns to DECAY.
  - abort in DECAY is ignored.
  - A start or abort in the same cycle as tick is processed first; the tick applies under the old state.
  - A state change takes effect for ticks from the next cycle onward.
- Channels are fully independent; any mix of states is legal.
- Arithmetic: the subtract/add is computed at WIDTH+1 bits, then clamped to 0 or MAX_LEVEL before it is written back.
- resetn asserted mid-refill: the channel goes immediately to DECAY at MAX_LEVEL; any pending done is lost.

Optional Feature:
PET_STAT_EXT_TICK_EN
- Defined:
  - the internal divider is removed and TICK_DIV is unused
  - adds input port tick_in (1 bit); each cycle with tick_in=1 acts as a tick
  - the tick output mirrors tick_in registered (1-cycle delay)
  - lets several stat banks share one rateDivider and gives fast simulation
- Undefined: the internal divider is used as described above, and there is no tick_in port.

Decomposition:
- Package pet_stat_pkg holds:
  - stat_state_t enum {ST_DECAY, ST_REFILL}
  - channel index localparams STAT_HUNGER=0, STAT_SLEEP=1
  - default MAX_LEVEL and LOW_THRESH constants
- Sub-module stat_channel is natural:
  - holds one channel's FSM, level register, saturating arithmetic and done/low/empty logic
  - instantiated NUM_STATS times in a generate loop
  - the top keeps the divider and the port packing

Test Plan:
- Bench settings: TICK_DIV=4, MAX_LEVEL=10, DECAY_STEP=1, REFILL_STEP=3, LOW_THRESH=2, NUM_STATS=2.
- Reset then 10 ticks: both levels step 10,9,...,0. empty=1 at 0, then stays 0 for 5 more ticks (no wrap). low=1 from level 2. tick period is exactly 4 cycles.
- Ch0 at level 1, pulse start[0]: refilling[0]=1 next cycle; ticks give 4,7,10. done[0] pulses exactly once, 1 cycle after the level reaches 10. Ch1 keeps decaying throughout.
- Ch1 refilling at 4, pulse abort[1]: refilling[1]=0 next cycle, level holds 4 then decays to 3 on the next tick, done[1] never asserts.
- start[0] while level[0]=10: done[0] pulses next cycle, refilling[0] stays 0. Also start[1]=abort[1]=1 in the same cycle: ch1 stays in DECAY.
- Assert resetn=0 asynchronously mid-refill, between clock edges: outputs go to reset values immediately (level=10, refilling=0, done=0). Re-run with PET_STAT_EXT_TICK_EN: levels change only on tick_in pulses.
